// File: rtl/comp_accum_bank.sv
// comp_accum_bank: a bank of CH signed accumulators that sums one tile of
// len input beats per channel and then holds the totals until the consumer
// takes them.
// Optional feature macro: COMP_ACC_SAT_EN. When it is defined, overflowing
// additions saturate. When it is not defined, they wrap.
// In both builds a signed overflow sets that channel's sticky ovf bit.
module comp_accum_bank #(
    parameter int CH    = 8,
    parameter int IN_W  = 33,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                in_valid,
    input  logic [CH*IN_W-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [CH*ACC_W-1:0] out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic [CH-1:0]       ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         len_q;
    logic signed [ACC_W-1:0]  acc     [CH];
    logic signed [ACC_W-1:0]  acc_nxt [CH];
    logic [CH-1:0]            ovf_now;

    // Per-channel add of the sign-extended slice, with overflow detection
    // and, optionally, clamping.
    always_comb begin
        logic signed [IN_W-1:0] slice;
        logic signed [ACC_W:0]  sum;
        ovf_now = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            slice      = in_data[c*IN_W +: IN_W];
            sum        = (ACC_W+1)'(acc[c]) + (ACC_W+1)'(slice);
            ovf_now[c] = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef COMP_ACC_SAT_EN
            if (ovf_now[c])
                acc_nxt[c] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_nxt[c] = sum[ACC_W-1:0];
`else
            acc_nxt[c] = sum[ACC_W-1:0];
`endif
        end
    end

    // Pack the accumulators onto the output bus.
    always_comb begin
        out_data = '0;
        for (int unsigned c = 0; c < CH; c++)
            out_data[c*ACC_W +: ACC_W] = acc[c];
    end

    // Tile FSM. The accumulators, counter and registered handshake outputs
    // are updated here. rst and clr override all other activity.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= IDLE;
            cnt       <= '0;
            ovf       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            if (rst)
                len_q <= '0;
            for (int unsigned c = 0; c < CH; c++)
                acc[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        ovf   <= '0;
                        len_q <= len;
                        busy  <= 1'b1;
                        for (int unsigned c = 0; c < CH; c++)
                            acc[c] <= '0;
                        if (len != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        cnt <= cnt + LEN_W'(1);
                        ovf <= ovf | ovf_now;
                        for (int unsigned c = 0; c < CH; c++)
                            acc[c] <= acc_nxt[c];
                        if (cnt == len_q - LEN_W'(1)) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_accum_bank.sv
// Directed testbench for comp_accum_bank with CH=2, IN_W=8, ACC_W=10 and
// LEN_W=4. The expected values are computed by hand.
module tb_comp_accum_bank;

    logic        clk = 1'b0;
    logic        rst, clr, start, in_valid, out_ready;
    logic [3:0]  len;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [19:0] out_data;
    logic [1:0]  ovf;

    int checks = 0;
    int errors = 0;

    comp_accum_bank #(.CH(2), .IN_W(8), .ACC_W(10), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Wait for the next rising edge, then move 1 ns past it so that
    // sampling and driving both happen away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bt(input int d1, input int d0);
        return {d1[7:0], d0[7:0]};
    endfunction

    function automatic logic [19:0] pk(input int a1, input int a0);
        return {a1[9:0], a0[9:0]};
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Test 1: len=3, three beats back to back.
        start = 1'b1; len = 4'd3; tick(); start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = bt(1, -2); tick();
        chk("t1_no_valid_b1", 32'(out_valid), 32'd0);
        in_data = bt(5, 3); tick();
        chk("t1_no_valid_b2", 32'(out_valid), 32'd0);
        in_data = bt(-7, 4); tick(); in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'(pk(-1, 5)));
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_in_ready_drain", 32'(in_ready), 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Test 2: len=2 with in_valid pattern 1,0,0,1, then output backpressure.
        start = 1'b1; len = 4'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(10, -20); tick();
        in_valid = 1'b0; in_data = bt(50, 50); tick(); tick();
        chk("t2_bubble_no_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = bt(-3, 7); tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_data", 32'(out_data), 32'(pk(7, -13)));
            tick();
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t2_valid_drop", 32'(out_valid), 32'd0);

        // Test 3: len=0 goes straight to DRAIN. Starts during DRAIN are ignored.
        start = 1'b1; len = 4'd0; tick(); start = 1'b0;
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_data", 32'(out_data), 32'd0);
        start = 1'b1; len = 4'd5; tick();
        chk("t3_start_ign_valid", 32'(out_valid), 32'd1);
        chk("t3_start_ign_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
        chk("t3_hs_valid", 32'(out_valid), 32'd0);
        chk("t3_hs_busy", 32'(busy), 32'd0);

        // Test 4: channel 0 overflows (5 * 127 = 635).
        start = 1'b1; len = 4'd5; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(0, 127);
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'd1);
`ifdef COMP_ACC_SAT_EN
        chk("t4_data", 32'(out_data), 32'(pk(0, 511)));
`else
        chk("t4_data", 32'(out_data), 32'(pk(0, -389)));
`endif
        chk("t4_ovf", 32'(ovf), 32'b01);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Test 5: clr with a simultaneous start after beat 2 of a len=4 tile.
        start = 1'b1; len = 4'd4; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(1, 2); tick();
        in_data = bt(3, 4); tick();
        clr = 1'b1; start = 1'b1; len = 4'd2; in_data = bt(9, 9); tick();
        clr = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_out_data", 32'(out_data), 32'd0);
        tick();
        chk("t5_start_not_taken", 32'(busy), 32'd0);
        start = 1'b1; len = 4'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(-5, 6); tick(); in_valid = 1'b0;
        chk("t5_new_valid", 32'(out_valid), 32'd1);
        chk("t5_new_data", 32'(out_data), 32'(pk(-5, 6)));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Test 6: rst during ACCUM discards the tile.
        start = 1'b1; len = 4'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(4, 4); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        start = 1'b1; len = 4'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = bt(2, -1); tick(); in_valid = 1'b0;
        chk("t6_new_data", 32'(out_data), 32'(pk(2, -1)));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_accum_bank.md
COMP_ACCUM_BANK -- requirements
Module: comp_accum_bank

Interface
REQ-001 Parameter CH, default 8: number of parallel compensation channels (one per array column).
REQ-002 Parameter IN_W, default 33: signed width of each incoming compensation partial sum.
REQ-003 Parameter ACC_W, default 40: signed accumulator width per channel; ACC_W >= IN_W.
REQ-004 Parameter LEN_W, default 8: width of the tile-length field.
REQ-005 clk  in  1  single clock; all logic is rising-edge triggered.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 clr  in  1  abort pulse; returns the block to idle.
REQ-008 start  in  1  pulse that begins a new accumulation tile.
REQ-009 len  in  LEN_W  number of input beats in the tile, sampled with start.
REQ-010 in_valid  in  1  in_data holds a valid beat.
REQ-011 in_data  in  CH*IN_W  packed signed partial sums; channel c is bits [c*IN_W +: IN_W].
REQ-012 in_ready  out  1  block accepts a beat this cycle.
REQ-013 out_valid  out  1  out_data holds completed tile results.
REQ-014 out_data  out  CH*ACC_W  packed signed accumulator values; channel c is bits [c*ACC_W +: ACC_W].
REQ-015 out_ready  in  1  consumer accepts out_data.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 ovf  out  CH  per-channel sticky overflow flags.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCUM and DRAIN.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 clears all accumulators and ovf, latches len and zeroes the beat counter.
REQ-020 From IDLE, start with len!=0 SHALL enter ACCUM next cycle; start with len==0 SHALL enter DRAIN next cycle with all-zero results.
REQ-021 ACCUM: in_ready=1; each cycle with in_valid=1 adds each sign-extended channel slice to its accumulator and increments the beat counter.
REQ-022 When the accepted beat is beat number len (counter==len-1), the FSM SHALL enter DRAIN on the next cycle, and the results SHALL include that beat.
REQ-023 A cycle in ACCUM with in_valid=0 SHALL leave accumulators and counter unchanged (bubbles allowed).
REQ-024 DRAIN: in_ready=0, out_valid=1, out_data equals the accumulators and SHALL stay stable until out_ready=1.
REQ-025 The out_valid&out_ready handshake SHALL return the FSM to IDLE; out_valid is 0 on the following cycle.
REQ-026 start SHALL be ignored outside IDLE, including in the cycle of the DRAIN handshake.
REQ-027 clr SHALL take priority over start, input beats and the output handshake: next cycle state=IDLE, accumulators=0, ovf=0.
REQ-028 Latency: out_valid rises exactly 1 cycle after the last beat is accepted; a fully fed tile of L beats occupies L+2 cycles from start to out_valid.
REQ-029 Signed overflow of a channel's addition SHALL set that channel's ovf bit, which holds until start, clr or rst.

Reset
REQ-030 On rst=1 at a rising edge: state=IDLE, accumulators=0, counter=0, ovf=0, out_valid=0, in_ready=0, busy=0.
REQ-031 rst asserted mid-tile SHALL discard the tile; no out_valid is produced for it.

Configuration
REQ-032 Macro COMP_ACC_SAT_EN defined: overflowing additions clamp to the signed max 2^(ACC_W-1)-1 or min -2^(ACC_W-1), and ovf is set.
REQ-033 Macro COMP_ACC_SAT_EN undefined: additions wrap modulo 2^ACC_W, and ovf is still set on signed overflow.

Verification (CH=2, IN_W=8, ACC_W=10, LEN_W=4)
REQ-034 Test 1: start, len=3; beats {ch1,ch0}={1,-2},{5,3},{-7,4} back-to-back -> out_valid 1 cycle after beat 3; out_data {-1,5}; ovf=0.
REQ-035 Test 2: len=2, in_valid pattern 1,0,0,1; out_ready held low 4 cycles -> out_data stable while held; sum includes both beats; out_valid drops the cycle after the handshake.
REQ-036 Test 3: start with len=0 -> DRAIN next cycle, out_data=0; a start pulse during DRAIN is ignored.
REQ-037 Test 4: len=5, five beats of ch0=127 (total 635 > 511) -> with COMP_ACC_SAT_EN ch0=511 and ovf[0]=1; without it ch0=-389 and ovf[0]=1; ovf[1]=0 in both builds.
REQ-038 Test 5: clr asserted after beat 2 of a len=4 tile, together with a start pulse -> next cycle IDLE, busy=0, ovf=0, start not taken; a new len=1 tile then returns only its own beat.
REQ-039 Test 6: rst asserted during ACCUM -> all outputs take their reset values next cycle; no out_valid until a new start.
